multdiv_sched: RTL and testbench

Sequencing controller between the execute stage and the multdiv unit. Accepts one multiply or divide request at a time, holds operands stable, issues the single-cycle ctrl_MULT/ctrl_DIV start pulse, and stalls the pipeline while the operation runs. Filters stale data_resultRDY, enforces a timeout, and hands a writeback packet (result or $rstatus exception code) to the writeback stage under a valid/ready handshake.

---
 rtl/multdiv_sched_if.sv | 47 ++++
 rtl/multdiv_sched.sv | 138 +++++++++++++
 tb/tb_multdiv_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_sched_if.sv
// Handshake and datapath bundle between execute, the multdiv sequencer, the multdiv unit
// and writeback. The slave modport is the sequencer's view; master is the surrounding pipeline.
interface multdiv_sched_if;
    // execute-stage request
    logic        req_valid;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        req_ready;
    logic        flush;
    logic        stall;

    // multdiv unit
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;

    // writeback packet
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, flush,
        input  md_result, md_exception, md_resultRDY,
        input  wb_ready,
        output req_ready, stall,
        output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        output wb_valid, wb_rd, wb_data, wb_exception
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, flush,
        output md_result, md_exception, md_resultRDY,
        output wb_ready,
        input  req_ready, stall,
        input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        input  wb_valid, wb_rd, wb_data, wb_exception
    );
endinterface

// File: rtl/multdiv_sched.sv
// Sequencer for the multdiv unit: accepts one request, pulses the start strobe, stalls the
// pipeline while it runs, and hands a result or exception packet to writeback.
module multdiv_sched #(
    parameter int TIMEOUT  = 40,
    parameter int MIN_LAT  = 2,
    parameter int EXC_RD   = 30,
    parameter int MULT_EXC = 1,
    parameter int DIV_EXC  = 2,
    parameter int TMO_EXC  = 3
) (
    input  logic                  clock,
    input  logic                  clrn,
    multdiv_sched_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0]  CNT_LAST   = 6'(TIMEOUT - 1);
    localparam logic [5:0]  CNT_MIN    = 6'(MIN_LAT);
    localparam logic [4:0]  EXC_RD_V   = 5'(EXC_RD);
    localparam logic [31:0] MULT_EXC_V = 32'(MULT_EXC);
    localparam logic [31:0] DIV_EXC_V  = 32'(DIV_EXC);
    localparam logic [31:0] TMO_EXC_V  = 32'(TMO_EXC);

    state_t      state_reg;
    logic [5:0]  count_reg;
    logic        op_reg;
    logic [4:0]  rd_reg;
    logic [31:0] operand_a_reg;
    logic [31:0] operand_b_reg;
    logic        wb_valid_reg;
    logic [4:0]  wb_rd_reg;
    logic [31:0] wb_data_reg;
    logic        wb_exception_reg;

    logic        accept;
    logic        rdy_honoured;
    logic        timed_out;

    // flush outranks everything, so a flushed request is never accepted
    assign accept       = (state_reg == IDLE) && bus.req_valid && !bus.flush;
    assign rdy_honoured = (count_reg >= CNT_MIN) && bus.md_resultRDY;
    assign timed_out    = (count_reg == CNT_LAST);

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_reg        <= IDLE;
            count_reg        <= 6'd0;
            op_reg           <= 1'b0;
            rd_reg           <= 5'd0;
            operand_a_reg    <= 32'd0;
            operand_b_reg    <= 32'd0;
            wb_valid_reg     <= 1'b0;
            wb_rd_reg        <= 5'd0;
            wb_data_reg      <= 32'd0;
            wb_exception_reg <= 1'b0;
        end else if (bus.flush) begin
            // operands stay put; only the in-flight operation and its packet are dropped
            state_reg        <= IDLE;
            count_reg        <= 6'd0;
            wb_valid_reg     <= 1'b0;
            wb_rd_reg        <= 5'd0;
            wb_data_reg      <= 32'd0;
            wb_exception_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    count_reg <= 6'd0;
                    if (accept) begin
                        operand_a_reg <= bus.req_a;
                        operand_b_reg <= bus.req_b;
                        op_reg        <= bus.req_op;
                        rd_reg        <= bus.req_rd;
                        state_reg     <= START;
                    end
                end

                START: begin
                    count_reg <= 6'd0;
                    state_reg <= BUSY;
                end

                BUSY: begin
                    count_reg <= count_reg + 6'd1;
                    if (rdy_honoured) begin
                        state_reg    <= DONE;
                        wb_valid_reg <= 1'b1;
                        if (bus.md_exception) begin
                            wb_rd_reg        <= EXC_RD_V;
                            wb_data_reg      <= op_reg ? DIV_EXC_V : MULT_EXC_V;
                            wb_exception_reg <= 1'b1;
                        end else begin
                            wb_rd_reg        <= rd_reg;
                            wb_data_reg      <= bus.md_result;
                            wb_exception_reg <= 1'b0;
                        end
                    end else if (timed_out) begin
                        state_reg        <= DONE;
                        wb_valid_reg     <= 1'b1;
                        wb_rd_reg        <= EXC_RD_V;
                        wb_data_reg      <= TMO_EXC_V;
                        wb_exception_reg <= 1'b1;
                    end
                end

                DONE: begin
                    // packet held until writeback takes it; no re-accept on this edge
                    if (bus.wb_ready) begin
                        wb_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = (state_reg == IDLE);
    assign bus.stall        = (state_reg != IDLE);
    assign bus.md_ctrl_MULT = (state_reg == START) && !op_reg;
    assign bus.md_ctrl_DIV  = (state_reg == START) &&  op_reg;

    assign bus.md_operandA  = operand_a_reg;
    assign bus.md_operandB  = operand_b_reg;
    assign bus.wb_valid     = wb_valid_reg;
    assign bus.wb_rd        = wb_rd_reg;
    assign bus.wb_data      = wb_data_reg;
    assign bus.wb_exception = wb_exception_reg;

endmodule

// File: tb/tb_multdiv_sched.sv
// Directed bench for multdiv_sched: a behavioural multdiv stand-in raises RDY at a chosen
// cycle after accept, and every observation goes through check_val.
module tb_multdiv_sched;

    localparam int TIMEOUT = 40;
    localparam int MIN_LAT = 2;

    logic clock = 1'b0;
    logic clrn  = 1'b0;

    multdiv_sched_if bus ();

    multdiv_sched #(
        .TIMEOUT  (TIMEOUT),
        .MIN_LAT  (MIN_LAT),
        .EXC_RD   (30),
        .MULT_EXC (1),
        .DIV_EXC  (2),
        .TMO_EXC  (3)
    ) dut (
        .clock (clock),
        .clrn  (clrn),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check_val({tag, "_stall"},     32'(bus.stall), 32'd0);
        check_val({tag, "_mult"},      32'(bus.md_ctrl_MULT), 32'd0);
        check_val({tag, "_div"},       32'(bus.md_ctrl_DIV), 32'd0);
        check_val({tag, "_opA"},       bus.md_operandA, 32'd0);
        check_val({tag, "_opB"},       bus.md_operandB, 32'd0);
        check_val({tag, "_wb_valid"},  32'(bus.wb_valid), 32'd0);
        check_val({tag, "_wb_rd"},     32'(bus.wb_rd), 32'd0);
        check_val({tag, "_wb_data"},   bus.wb_data, 32'd0);
        check_val({tag, "_wb_exc"},    32'(bus.wb_exception), 32'd0);
    endtask

    // One full operation: accept, run the RDY model, check the packet, optionally
    // hold wb_ready low for bp cycles while offering the follow-up request, then handshake.
    task automatic do_op(input string tag, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int rdy_cyc,
                         input logic exc, input logic [31:0] res, input int exp_cyc,
                         input logic [4:0] exp_rd, input logic [31:0] exp_data,
                         input logic exp_exc, input int bp);
        int wb_cyc    = -1;
        int mult_n    = 0;
        int div_n     = 0;
        int pulse_cyc = -1;
        int stall_low = 0;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
        bus.req_valid = 1'b1;
        check_val({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check_val({tag, "_opA"}, bus.md_operandA, a);
        check_val({tag, "_opB"}, bus.md_operandB, b);
        for (int c = 1; c <= 60; c++) begin
            if (bus.wb_valid) begin
                wb_cyc = c;
                break;
            end
            if (bus.md_ctrl_MULT) begin mult_n++; pulse_cyc = c; end
            if (bus.md_ctrl_DIV)  begin div_n++;  pulse_cyc = c; end
            if (!bus.stall) stall_low++;
            bus.md_resultRDY = (c >= rdy_cyc);
            bus.md_result    = res;
            bus.md_exception = exc;
            tick();
        end
        bus.md_resultRDY = 1'b0;
        check_val({tag, "_mult_pulses"}, 32'(mult_n), op ? 32'd0 : 32'd1);
        check_val({tag, "_div_pulses"},  32'(div_n),  op ? 32'd1 : 32'd0);
        check_val({tag, "_pulse_cyc"},   32'(pulse_cyc), 32'd1);
        check_val({tag, "_stall_low"},   32'(stall_low), 32'd0);
        check_val({tag, "_wb_cyc"},      32'(wb_cyc), 32'(exp_cyc));
        check_val({tag, "_wb_rd"},       32'(bus.wb_rd), 32'(exp_rd));
        check_val({tag, "_wb_data"},     bus.wb_data, exp_data);
        check_val({tag, "_wb_exc"},      32'(bus.wb_exception), 32'(exp_exc));
        for (int i = 0; i < bp; i++) begin
            bus.req_op    = 1'b0;
            bus.req_a     = 32'd99;
            bus.req_b     = 32'd3;
            bus.req_rd    = 5'd7;
            bus.req_valid = 1'b1;
            tick();
            check_val({tag, "_bp_valid"}, 32'(bus.wb_valid), 32'd1);
            check_val({tag, "_bp_data"},  bus.wb_data, exp_data);
            check_val({tag, "_bp_rd"},    32'(bus.wb_rd), 32'(exp_rd));
            check_val({tag, "_bp_ready"}, 32'(bus.req_ready), 32'd0);
            check_val({tag, "_bp_opA"},   bus.md_operandA, a);
        end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        check_val({tag, "_post_stall"}, 32'(bus.stall), 32'd0);
        check_val({tag, "_post_ready"}, 32'(bus.req_ready), 32'd1);
        check_val({tag, "_post_valid"}, 32'(bus.wb_valid), 32'd0);
        check_val({tag, "_post_opA"},   bus.md_operandA, a);
        $display("op %s: wb_cyc=%0d rd=%0d data=0x%08h exc=%0d", tag, wb_cyc, bus.wb_rd,
                 exp_data, exp_exc);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_op       = 1'b0;
        bus.req_a        = 32'd0;
        bus.req_b        = 32'd0;
        bus.req_rd       = 5'd0;
        bus.flush        = 1'b0;
        bus.md_result    = 32'd0;
        bus.md_exception = 1'b0;
        bus.md_resultRDY = 1'b0;
        bus.wb_ready     = 1'b0;

        #2;
        check_reset_outputs("reset");
        #10 clrn = 1'b1;
        tick();

        do_op("mult", 1'b0, 32'd6, 32'd7, 5'd5, 33, 1'b0, 32'd42, 34,
              5'd5, 32'd42, 1'b0, 0);
        do_op("div", 1'b1, 32'hFFFF_FFEC, 32'd3, 5'd9, 20, 1'b0, 32'hFFFF_FFFA, 21,
              5'd9, 32'hFFFF_FFFA, 1'b0, 0);
        do_op("div0", 1'b1, 32'd5, 32'd0, 5'd9, 10, 1'b1, 32'd0, 11,
              5'd30, 32'd2, 1'b1, 0);
        do_op("mult_exc", 1'b0, 32'h8000_0000, 32'd4, 5'd6, 5, 1'b1, 32'd0, 6,
              5'd30, 32'd1, 1'b1, 0);

        // RDY already high in IDLE: first honoured at BUSY count MIN_LAT (cycle 4)
        bus.md_resultRDY = 1'b1;
        do_op("stale", 1'b0, 32'd3, 32'd5, 5'd2, 0, 1'b0, 32'd15, 2 + MIN_LAT + 1,
              5'd2, 32'd15, 1'b0, 0);

        do_op("timeout", 1'b1, 32'd100, 32'd7, 5'd8, 1000, 1'b0, 32'd14, TIMEOUT + 2,
              5'd30, 32'd3, 1'b1, 0);

        // backpressure; the offered request is accepted in the cycle after the handshake
        do_op("bp", 1'b0, 32'd2, 32'd9, 5'd4, 8, 1'b0, 32'd18, 9,
              5'd4, 32'd18, 1'b0, 5);
        do_op("after_bp", 1'b0, 32'd99, 32'd3, 5'd7, 6, 1'b0, 32'd297, 7,
              5'd7, 32'd297, 1'b0, 0);

        // flush in BUSY count 10 (cycle 12)
        bus.req_op    = 1'b0;
        bus.req_a     = 32'd11;
        bus.req_b     = 32'd12;
        bus.req_rd    = 5'd3;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        check_val("flush_pre_stall", 32'(bus.stall), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_val("flush_stall",    32'(bus.stall), 32'd0);
        check_val("flush_ready",    32'(bus.req_ready), 32'd1);
        check_val("flush_wb_valid", 32'(bus.wb_valid), 32'd0);
        check_val("flush_opA",      bus.md_operandA, 32'd11);
        $display("flush in BUSY: stall=%0d wb_valid=%0d", bus.stall, bus.wb_valid);

        // flush in IDLE blocks acceptance
        bus.req_a     = 32'd55;
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check_val("idle_flush_stall", 32'(bus.stall), 32'd0);
        check_val("idle_flush_opA",   bus.md_operandA, 32'd11);
        for (int c = 0; c < 3; c++) tick();
        check_val("idle_flush_mult",  32'(bus.md_ctrl_MULT), 32'd0);
        $display("flush in IDLE: stall=%0d opA=%0d", bus.stall, bus.md_operandA);

        // asynchronous reset mid-BUSY
        bus.req_op    = 1'b1;
        bus.req_a     = 32'd13;
        bus.req_b     = 32'd14;
        bus.req_rd    = 5'd1;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check_val("mid_stall", 32'(bus.stall), 32'd1);
        #2 clrn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        #2 clrn = 1'b1;
        tick();
        check_reset_outputs("post_rst");
        $display("reset mid-BUSY: stall=%0d wb_valid=%0d", bus.stall, bus.wb_valid);

        do_op("recover", 1'b0, 32'd10, 32'd10, 5'd12, 7, 1'b0, 32'd100, 8,
              5'd12, 32'd100, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
